// File: rtl/exe_stage_ctrl_pkg.sv
// Shared definitions for the EXE stage controller: state encodings, default
// outstanding-request depth and the helper that picks the EXE entry state.
package exe_stage_ctrl_pkg;

   typedef enum logic [1:0] {
      EXE_IDLE = 2'd0,
      EXE_REQ  = 2'd1,
      EXE_DIV  = 2'd2,
      EXE_DONE = 2'd3
   } exe_state_e;

   localparam int unsigned MAX_OUTSTANDING_DEF = 2;
   localparam int unsigned CNT_W_DEF           = 2;

   // An instruction that already carries an exception does no SRAM or divider work.
   function automatic exe_state_e entry_state(input logic has_ex,
                                              input logic need_mem,
                                              input logic is_div);
      exe_state_e st;
      if (has_ex)        st = EXE_DONE;
      else if (need_mem) st = EXE_REQ;
      else if (is_div)   st = EXE_DIV;
      else               st = EXE_DONE;
      return st;
   endfunction

endpackage

// File: rtl/exe_stage_ctrl_if.sv
// Handshake bundle between the EXE controller and its neighbours (ID, MEM, WB,
// divider, data SRAM). slave = controller side, master = environment side.
interface exe_stage_ctrl_if;

   logic id_to_exe_valid;
   logic id_need_mem;
   logic id_is_div;
   logic id_has_ex;
   logic flush;
   logic mem_allow_in;
   logic div_done;
   logic data_addr_ok;
   logic data_data_ok;

   logic exe_allow_in;
   logic exe_load_en;
   logic exe_valid;
   logic exe_ready_go;
   logic exe_to_mem_valid;
   logic div_start;
   logic data_req;
   logic mem_data_ok;
   logic cancel_pending;

   modport slave (
      input  id_to_exe_valid, id_need_mem, id_is_div, id_has_ex, flush,
             mem_allow_in, div_done, data_addr_ok, data_data_ok,
      output exe_allow_in, exe_load_en, exe_valid, exe_ready_go,
             exe_to_mem_valid, div_start, data_req, mem_data_ok, cancel_pending
   );

   modport master (
      output id_to_exe_valid, id_need_mem, id_is_div, id_has_ex, flush,
             mem_allow_in, div_done, data_addr_ok, data_data_ok,
      input  exe_allow_in, exe_load_en, exe_valid, exe_ready_go,
             exe_to_mem_valid, div_start, data_req, mem_data_ok, cancel_pending
   );

endinterface

// File: rtl/exe_stage_ctrl_sram_cancel_tracker.sv
// Counts accepted data-SRAM requests awaiting data_ok and, after a flush, how many
// of those returns belong to squashed instructions and must be swallowed.
module exe_stage_ctrl_sram_cancel_tracker
   import exe_stage_ctrl_pkg::*;
#(
   parameter int unsigned MAX_OUTSTANDING = MAX_OUTSTANDING_DEF,
   parameter int unsigned CNT_W           = CNT_W_DEF
) (
   input  logic clk,
   input  logic resetn,
   input  logic accept_i,
   input  logic data_ok_i,
   input  logic flush_i,
   output logic full_o,
   output logic mem_data_ok_o,
   output logic cancel_pending_o
);

   logic [CNT_W-1:0] outstanding_q, outstanding_d;
   logic [CNT_W-1:0] cancel_cnt_q, cancel_cnt_d;
   logic             discard;

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         outstanding_q <= '0;
         cancel_cnt_q  <= '0;
      end else begin
         outstanding_q <= outstanding_d;
         cancel_cnt_q  <= cancel_cnt_d;
      end
   end

   // Returns are in order, so the oldest cancel_cnt returns are the squashed ones.
   always_comb begin
      discard       = data_ok_i && (cancel_cnt_q != '0);
      outstanding_d = outstanding_q + CNT_W'(accept_i) - CNT_W'(data_ok_i);
      cancel_cnt_d  = cancel_cnt_q;
      if (flush_i)      cancel_cnt_d = outstanding_d;
      else if (discard) cancel_cnt_d = cancel_cnt_q - CNT_W'(1);
   end

   assign full_o           = (outstanding_q >= CNT_W'(MAX_OUTSTANDING));
   assign mem_data_ok_o    = data_ok_i && !discard;
   assign cancel_pending_o = (cancel_cnt_q != '0);

endmodule

// File: rtl/exe_stage_ctrl.sv
// EXE pipeline-register sequencer: valid/handshake, divider start, data-SRAM request
// and flush handling; in-flight SRAM bookkeeping lives in the tracker sub-module.
//
//   state    | meaning
//   ---------+-----------------------------------------------------------
//   EXE_IDLE | EXE register empty
//   EXE_REQ  | load/store waiting for data SRAM to accept the address
//   EXE_DIV  | divide in progress, waiting for div_done
//   EXE_DONE | work complete, waiting for MEM to take the instruction
module exe_stage_ctrl
   import exe_stage_ctrl_pkg::*;
#(
   parameter int unsigned MAX_OUTSTANDING = MAX_OUTSTANDING_DEF,
   parameter int unsigned CNT_W           = CNT_W_DEF
) (
   input logic             clk,
   input logic             resetn,
   exe_stage_ctrl_if.slave bus
);

   exe_state_e state_q, state_d;
   exe_state_e entry;
   logic       div_first_q, div_first_d;

   logic allow_in;
   logic load_en;
   logic req_raw;
   logic accept;
   logic full;
   logic trk_mem_data_ok;
   logic trk_cancel_pending;

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q     <= EXE_IDLE;
         div_first_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         div_first_q <= div_first_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      div_first_d = 1'b0;
      if (bus.flush) begin
         state_d = EXE_IDLE;
      end else if (load_en) begin
         state_d     = entry;
         div_first_d = (entry == EXE_DIV);
      end else begin
         unique case (state_q)
            EXE_DONE: if (bus.mem_allow_in) state_d = EXE_IDLE;
            EXE_REQ:  if (accept) state_d = EXE_DONE;
            EXE_DIV:  if (bus.div_done && !div_first_q) state_d = EXE_DONE;
            default:  state_d = state_q;
         endcase
      end
   end

   // The accept is taken from the unflushed request: an address the SRAM latches in
   // the flush cycle is still in flight and must be counted for cancellation.
   always_comb begin
      entry    = entry_state(bus.id_has_ex, bus.id_need_mem, bus.id_is_div);
      allow_in = (state_q == EXE_IDLE) || ((state_q == EXE_DONE) && bus.mem_allow_in);
      load_en  = allow_in && bus.id_to_exe_valid && !bus.flush;
      req_raw  = (state_q == EXE_REQ) && !full;
      accept   = req_raw && bus.data_addr_ok;
   end

   assign bus.exe_allow_in     = allow_in;
   assign bus.exe_load_en      = load_en;
   assign bus.exe_valid        = (state_q != EXE_IDLE);
   assign bus.exe_ready_go     = (state_q == EXE_DONE);
   assign bus.exe_to_mem_valid = (state_q == EXE_DONE);
   assign bus.data_req         = req_raw && !bus.flush;
   assign bus.div_start        = (state_q == EXE_DIV) && div_first_q && !bus.flush;
   assign bus.mem_data_ok      = trk_mem_data_ok;
   assign bus.cancel_pending   = trk_cancel_pending;

   exe_stage_ctrl_sram_cancel_tracker #(
      .MAX_OUTSTANDING (MAX_OUTSTANDING),
      .CNT_W           (CNT_W)
   ) u_trk (
      .clk              (clk),
      .resetn           (resetn),
      .accept_i         (accept),
      .data_ok_i        (bus.data_data_ok),
      .flush_i          (bus.flush),
      .full_o           (full),
      .mem_data_ok_o    (trk_mem_data_ok),
      .cancel_pending_o (trk_cancel_pending)
   );

endmodule

// File: tb/tb_exe_stage_ctrl.sv
// Directed bench for exe_stage_ctrl: ALU flow, load stall, divide, flush cancel,
// backpressure/full and asynchronous reset, with hand-computed expectations.
module tb_exe_stage_ctrl;

   logic clk;
   logic resetn;
   int   n_tests;
   int   n_fail;

   exe_stage_ctrl_if bus ();

   exe_stage_ctrl dut (
      .clk    (clk),
      .resetn (resetn),
      .bus    (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clr_in();
      bus.id_to_exe_valid = 1'b0;
      bus.id_need_mem     = 1'b0;
      bus.id_is_div       = 1'b0;
      bus.id_has_ex       = 1'b0;
      bus.flush           = 1'b0;
      bus.div_done        = 1'b0;
      bus.data_addr_ok    = 1'b0;
      bus.data_data_ok    = 1'b0;
   endtask

   task automatic ld_mem();
      bus.id_to_exe_valid = 1'b1;
      bus.id_need_mem     = 1'b1;
   endtask

   initial begin
      n_tests = 0;
      n_fail  = 0;
      resetn  = 1'b0;
      clr_in();
      bus.mem_allow_in = 1'b1;

      // reset state
      #2;
      chk("rst_valid",     bus.exe_valid,        1'b0);
      chk("rst_ready_go",  bus.exe_ready_go,     1'b0);
      chk("rst_to_mem",    bus.exe_to_mem_valid, 1'b0);
      chk("rst_data_req",  bus.data_req,         1'b0);
      chk("rst_div_start", bus.div_start,        1'b0);
      chk("rst_mem_ok",    bus.mem_data_ok,      1'b0);
      chk("rst_cancel",    bus.cancel_pending,   1'b0);
      chk("rst_allow_in",  bus.exe_allow_in,     1'b1);
      tick();
      tick();
      resetn = 1'b1;

      // 1: ALU flow, three back-to-back single-cycle instructions
      for (int i = 0; i < 3; i++) begin
         bus.id_to_exe_valid = 1'b1;
         #2;
         chk("alu_allow_in", bus.exe_allow_in, 1'b1);
         chk("alu_load_en",  bus.exe_load_en,  1'b1);
         if (i > 0) chk("alu_to_mem", bus.exe_to_mem_valid, 1'b1);
         tick();
      end
      clr_in();
      #2;
      chk("alu_last_to_mem", bus.exe_to_mem_valid, 1'b1);
      tick();
      #2;
      chk("alu_idle", bus.exe_valid, 1'b0);

      // 2: load stall, address accepted on the fourth request cycle
      ld_mem();
      #2;
      chk("ld_load_en", bus.exe_load_en, 1'b1);
      tick();
      for (int i = 0; i < 4; i++) begin
         bus.data_addr_ok = (i == 3);
         #2;
         chk("ld_req",      bus.data_req,     1'b1);
         chk("ld_allow_in", bus.exe_allow_in, 1'b0);
         chk("ld_no_load",  bus.exe_load_en,  1'b0);
         chk("ld_not_done", bus.exe_ready_go, 1'b0);
         tick();
      end
      clr_in();
      #2;
      chk("ld_done",      bus.exe_ready_go,     1'b1);
      chk("ld_to_mem",    bus.exe_to_mem_valid, 1'b1);
      chk("ld_req_off",   bus.data_req,         1'b0);
      tick();
      bus.data_data_ok = 1'b1;
      #2;
      chk("ld_mem_ok", bus.mem_data_ok, 1'b1);
      tick();
      clr_in();

      // 3: divide; div_done in the start cycle must be ignored
      bus.id_to_exe_valid = 1'b1;
      bus.id_is_div       = 1'b1;
      tick();
      clr_in();
      bus.div_done = 1'b1;
      #2;
      chk("div_start_pulse", bus.div_start, 1'b1);
      tick();
      bus.div_done = 1'b0;
      #2;
      chk("div_start_once",   bus.div_start,    1'b0);
      chk("div_early_ignore", bus.exe_ready_go, 1'b0);
      chk("div_valid",        bus.exe_valid,    1'b1);
      for (int i = 0; i < 9; i++) tick();
      bus.div_done = 1'b1;
      #2;
      chk("div_wait", bus.exe_ready_go, 1'b0);
      tick();
      bus.div_done = 1'b0;
      #2;
      chk("div_done",   bus.exe_ready_go,     1'b1);
      chk("div_to_mem", bus.exe_to_mem_valid, 1'b1);
      tick();

      // 4: flush coincident with an address accept, outstanding=1 beforehand
      ld_mem();
      tick();
      clr_in();
      bus.data_addr_ok = 1'b1;
      tick();
      clr_in();
      ld_mem();
      #2;
      chk("fl_reload", bus.exe_load_en, 1'b1);
      tick();
      clr_in();
      bus.data_addr_ok = 1'b1;
      bus.flush        = 1'b1;
      #2;
      chk("fl_req_gated", bus.data_req,    1'b0);
      chk("fl_no_load",   bus.exe_load_en, 1'b0);
      tick();
      clr_in();
      bus.data_data_ok = 1'b1;
      #2;
      chk("fl_idle",       bus.exe_valid,      1'b0);
      chk("fl_pending1",   bus.cancel_pending, 1'b1);
      chk("fl_discard1",   bus.mem_data_ok,    1'b0);
      tick();
      #2;
      chk("fl_pending2",   bus.cancel_pending, 1'b1);
      chk("fl_discard2",   bus.mem_data_ok,    1'b0);
      tick();
      clr_in();
      ld_mem();
      #2;
      chk("fl_pending0",   bus.cancel_pending, 1'b0);
      tick();
      clr_in();
      bus.data_addr_ok = 1'b1;
      tick();
      clr_in();
      bus.data_data_ok = 1'b1;
      #2;
      chk("fl_third_ok", bus.mem_data_ok, 1'b1);
      tick();
      clr_in();

      // 5: backpressure in DONE, then outstanding reaching two blocks data_req
      ld_mem();
      tick();
      clr_in();
      bus.data_addr_ok = 1'b1;
      tick();
      clr_in();
      ld_mem();
      bus.mem_allow_in = 1'b0;
      #2;
      chk("bp_allow_in", bus.exe_allow_in, 1'b0);
      chk("bp_no_load",  bus.exe_load_en,  1'b0);
      tick();
      #2;
      chk("bp_hold", bus.exe_ready_go, 1'b1);
      bus.mem_allow_in = 1'b1;
      tick();
      clr_in();
      bus.data_addr_ok = 1'b1;
      tick();
      clr_in();
      ld_mem();
      tick();
      clr_in();
      bus.data_addr_ok = 1'b1;
      #2;
      chk("full_req_off", bus.data_req, 1'b0);
      tick();
      bus.data_data_ok = 1'b1;
      #2;
      chk("full_req_off2", bus.data_req,    1'b0);
      chk("full_mem_ok",   bus.mem_data_ok, 1'b1);
      tick();
      bus.data_data_ok = 1'b0;
      #2;
      chk("full_req_back", bus.data_req, 1'b1);
      tick();
      clr_in();
      bus.data_data_ok = 1'b1;
      #2;
      chk("full_done", bus.exe_ready_go, 1'b1);
      tick();
      tick();
      clr_in();

      // 6: asynchronous reset while REQ with a cancel pending
      ld_mem();
      tick();
      clr_in();
      bus.data_addr_ok = 1'b1;
      tick();
      clr_in();
      bus.flush = 1'b1;
      tick();
      clr_in();
      ld_mem();
      #2;
      chk("ar_pending", bus.cancel_pending, 1'b1);
      tick();
      clr_in();
      #2;
      chk("ar_req_before", bus.data_req, 1'b1);
      #2;
      resetn = 1'b0;
      #1;
      chk("ar_req",      bus.data_req,       1'b0);
      chk("ar_valid",    bus.exe_valid,      1'b0);
      chk("ar_allow_in", bus.exe_allow_in,   1'b1);
      chk("ar_cancel",   bus.cancel_pending, 1'b0);
      tick();
      resetn = 1'b1;
      ld_mem();
      tick();
      clr_in();
      bus.data_addr_ok = 1'b1;
      tick();
      clr_in();
      bus.data_data_ok = 1'b1;
      #2;
      chk("ar_mem_ok", bus.mem_data_ok, 1'b1);
      tick();
      clr_in();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
